// File: rtl/sliced_add_sub_unit.sv
// Multi-cycle WIDTH-bit adder/subtractor: one SLICE-bit chunk per clock through a registered carry chain.
// Keeps a registered result and C/Z/V/N flags so ADC/SBC can chain multi-precision arithmetic.
module sliced_add_sub_unit #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_flag,
  output logic             z_flag,
  output logic             v_flag,
  output logic             n_flag
);

  localparam int NSL = WIDTH / SLICE;
  localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSL - 1);

  generate
    if ((WIDTH % SLICE) != 0) begin : g_bad_slice
      $error("sliced_add_sub_unit: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  // Handshake: start is accepted on an edge where state is IDLE (including the
  // done cycle); busy stays high until the completing edge, which raises done
  // for exactly one cycle together with the new result and flags.
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t state, state_next;

  logic [NSL-1:0][SLICE-1:0] a_q, b_q, shadow, shadow_next;
  logic                      carry;
  logic [KW-1:0]             k;
  logic [SLICE:0]            slice_sum;
  logic                      accept;

  assign accept = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (k == K_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One slice of the ripple: the carry register links consecutive clocks.
  always_comb begin
    slice_sum      = {1'b0, a_q[k]} + {1'b0, b_q[k]} + {{SLICE{1'b0}}, carry};
    shadow_next    = shadow;
    shadow_next[k] = slice_sum[SLICE-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      shadow <= '0;
      carry  <= 1'b0;
      k      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      c_flag <= 1'b0;
      z_flag <= 1'b0;
      v_flag <= 1'b0;
      n_flag <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_q   <= a;
        b_q   <= op[0] ? ~b : b;
        carry <= op[1] ? c_flag : op[0];
        k     <= '0;
        busy  <= 1'b1;
      end else if (state == BUSY) begin
        shadow <= shadow_next;
        carry  <= slice_sum[SLICE];
        k      <= k + KW'(1);
        if (k == K_LAST) begin
          result <= shadow_next;
          c_flag <= slice_sum[SLICE];
          z_flag <= (shadow_next == '0);
          n_flag <= shadow_next[NSL-1][SLICE-1];
          v_flag <= (a_q[NSL-1][SLICE-1] == b_q[NSL-1][SLICE-1]) &&
                    (shadow_next[NSL-1][SLICE-1] != a_q[NSL-1][SLICE-1]);
          busy   <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sliced_add_sub_unit.sv
// Bench for sliced_add_sub_unit: three instances (SLICE 4, 1, 8) against a table, corner sequences
// and a signed/unsigned integer reference model.
module tb_sliced_add_sub_unit;

  localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_ADC = 2'b10, OP_SBC = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] op_s;
  logic [7:0] a_s, b_s;
  logic       start_v [3];
  logic       busy_v  [3];
  logic       done_v  [3];
  logic [7:0] res_v   [3];
  logic       c_v [3], z_v [3], v_v [3], n_v [3];

  int   checks = 0;
  int   errors = 0;
  logic exp_c [3];
  logic [11:0] exp_q [$];
  int   nsl [3] = '{2, 8, 1};

  always #5 clk = ~clk;

  sliced_add_sub_unit #(.WIDTH(8), .SLICE(4)) u_s4 (
    .clk(clk), .rst(rst), .start(start_v[0]), .op(op_s), .a(a_s), .b(b_s),
    .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0]),
    .c_flag(c_v[0]), .z_flag(z_v[0]), .v_flag(v_v[0]), .n_flag(n_v[0]));

  sliced_add_sub_unit #(.WIDTH(8), .SLICE(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .op(op_s), .a(a_s), .b(b_s),
    .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1]),
    .c_flag(c_v[1]), .z_flag(z_v[1]), .v_flag(v_v[1]), .n_flag(n_v[1]));

  sliced_add_sub_unit #(.WIDTH(8), .SLICE(8)) u_s8 (
    .clk(clk), .rst(rst), .start(start_v[2]), .op(op_s), .a(a_s), .b(b_s),
    .busy(busy_v[2]), .done(done_v[2]), .result(res_v[2]),
    .c_flag(c_v[2]), .z_flag(z_v[2]), .v_flag(v_v[2]), .n_flag(n_v[2]));

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [11:0] exp;   // {result, C, Z, V, N}
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
    end
  endtask

  function automatic logic [11:0] outs(input int u);
    return {res_v[u], c_v[u], z_v[u], v_v[u], n_v[u]};
  endfunction

  // Reference: plain integer arithmetic, unsigned for C, signed range for V.
  function automatic logic [11:0] model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                        input logic cf);
    int cin, s, ss, sa, sb;
    logic [7:0] r;
    logic c, v;
    cin = (op == OP_ADD) ? 0 : (op == OP_SUB) ? 1 : int'(cf);
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    if (!op[0]) begin
      s  = int'(a) + int'(b) + cin;
      c  = (s > 255);
      ss = sa + sb + cin;
    end else begin
      s  = int'(a) - int'(b) - (1 - cin);
      c  = (s >= 0);
      ss = sa - sb - (1 - cin);
    end
    r = s[7:0];
    v = (ss > 127) || (ss < -128);
    return {r, c, (r == 8'h00), v, r[7]};
  endfunction

  task automatic do_op(input int u, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [11:0] got, output int lat);
    int n = 0;
    @(negedge clk);
    while (busy_v[u] && n < 50) begin
      @(negedge clk);
      n++;
    end
    start_v[u] = 1'b1;
    op_s = op;
    a_s  = a;
    b_s  = b;
    @(negedge clk);
    start_v[u] = 1'b0;
    lat = 0;
    while (!done_v[u] && lat < 40) begin
      check($sformatf("busy_during_op_u%0d", u), 32'(busy_v[u]), 32'd1);
      @(negedge clk);
      lat++;
    end
    got = outs(u);
    check($sformatf("busy_at_done_u%0d", u), 32'(busy_v[u]), 32'd0);
    @(negedge clk);
    check($sformatf("done_one_cycle_u%0d", u), 32'(done_v[u]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] got, e;
    int lat;

    vecs[0] = '{OP_ADD, 8'h3C, 8'h15, {8'h51, 4'b0000}};
    vecs[1] = '{OP_SUB, 8'h10, 8'h20, {8'hF0, 4'b0001}};
    vecs[2] = '{OP_ADD, 8'h7F, 8'h01, {8'h80, 4'b0011}};
    vecs[3] = '{OP_ADD, 8'hFF, 8'h01, {8'h00, 4'b1100}};
    vecs[4] = '{OP_ADC, 8'h00, 8'h00, {8'h01, 4'b0000}};
    vecs[5] = '{OP_SUB, 8'h80, 8'h01, {8'h7F, 4'b1010}};
    vecs[6] = '{OP_SBC, 8'h05, 8'h03, {8'h02, 4'b1000}};
    vecs[7] = '{OP_ADD, 8'h00, 8'h00, {8'h00, 4'b0100}};
    vecs[8] = '{OP_SBC, 8'h00, 8'h00, {8'hFF, 4'b0001}};

    // Clock/reset
    rst = 1'b1;
    for (int u = 0; u < 3; u++) start_v[u] = 1'b0;
    op_s = OP_ADD; a_s = 8'h00; b_s = 8'h00;
    repeat (2) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      check($sformatf("reset_outs_u%0d", u), 32'(outs(u)), 32'd0);
      check($sformatf("reset_busy_u%0d", u), 32'(busy_v[u]), 32'd0);
      check($sformatf("reset_done_u%0d", u), 32'(done_v[u]), 32'd0);
    end
    rst = 1'b0;

    // Directed table on SLICE=4
    for (int i = 0; i < 9; i++) begin
      do_op(0, vecs[i].op, vecs[i].a, vecs[i].b, got, lat);
      check($sformatf("table%0d_latency", i), 32'(lat), 32'd2);
      check($sformatf("table%0d_outs", i), 32'(got), 32'(vecs[i].exp));
    end

    // Start while busy is ignored; start in the done cycle is accepted
    @(negedge clk);
    start_v[0] = 1'b1; op_s = OP_ADD; a_s = 8'h3C; b_s = 8'h15;
    @(negedge clk);
    check("ign_busy_t0", 32'(busy_v[0]), 32'd1);
    a_s = 8'h11; b_s = 8'h22;
    @(negedge clk);
    check("ign_no_done_t1", 32'(done_v[0]), 32'd0);
    @(negedge clk);
    check("ign_done_t2", 32'(done_v[0]), 32'd1);
    check("ign_result_intact", 32'(outs(0)), 32'({8'h51, 4'b0000}));
    @(negedge clk);
    start_v[0] = 1'b0;
    check("b2b_busy", 32'(busy_v[0]), 32'd1);
    check("b2b_result_held", 32'(res_v[0]), 32'h51);
    @(negedge clk);
    check("b2b_no_done_early", 32'(done_v[0]), 32'd0);
    @(negedge clk);
    check("b2b_done", 32'(done_v[0]), 32'd1);
    check("b2b_result", 32'(outs(0)), 32'({8'h33, 4'b0000}));

    // Reset one cycle after accept aborts the op
    @(negedge clk);
    start_v[0] = 1'b1; op_s = OP_ADD; a_s = 8'hFF; b_s = 8'h01;
    @(negedge clk);
    start_v[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("abort_outs", 32'(outs(0)), 32'd0);
    check("abort_busy", 32'(busy_v[0]), 32'd0);
    check("abort_done", 32'(done_v[0]), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done_v[0]), 32'd0);
      check("abort_result_zero", 32'(res_v[0]), 32'd0);
    end
    do_op(0, OP_ADD, 8'h01, 8'h01, got, lat);
    check("after_abort_latency", 32'(lat), 32'd2);
    check("after_abort_outs", 32'(got), 32'({8'h02, 4'b0000}));

    // SLICE=1: eight-cycle latency
    do_op(1, OP_ADD, 8'hAA, 8'h55, got, lat);
    check("s1_latency", 32'(lat), 32'd8);
    check("s1_outs", 32'(got), 32'({8'hFF, 4'b0001}));

    // SLICE=8: single-cycle latency, SBC with C=1
    do_op(2, OP_ADD, 8'hFF, 8'h01, got, lat);
    check("s8_setc_latency", 32'(lat), 32'd1);
    check("s8_setc_outs", 32'(got), 32'({8'h00, 4'b1100}));
    do_op(2, OP_SBC, 8'h05, 8'h03, got, lat);
    check("s8_sbc_latency", 32'(lat), 32'd1);
    check("s8_sbc_outs", 32'(got), 32'({8'h02, 4'b1000}));

    // Randomized ops against the reference model
    exp_c[0] = 1'b0;
    exp_c[1] = 1'b0;
    exp_c[2] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      for (int u = 0; u < 3; u++) begin
        logic [1:0] rop;
        logic [7:0] ra, rb;
        rop = 2'($urandom_range(0, 3));
        ra  = 8'($urandom_range(0, 255));
        rb  = 8'($urandom_range(0, 255));
        exp_q.push_back(model(rop, ra, rb, exp_c[u]));
        do_op(u, rop, ra, rb, got, lat);
        e = exp_q.pop_front();
        check($sformatf("rand_latency_u%0d", u), 32'(lat), 32'(nsl[u]));
        check($sformatf("rand_outs_u%0d_op%0d_%02h_%02h", u, rop, ra, rb), 32'(got), 32'(e));
        exp_c[u] = e[3];
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
